// File: rtl/pp_stage_sequencer_pkg.sv
// Shared definitions for the pipelined stage sequencer and the JPEG top:
// FSM encodings and default geometry.
package pp_stage_sequencer_pkg;

  localparam int unsigned PP_ADDR_W     = 15;
  localparam int unsigned PP_BLK_LOG2   = 3;
  localparam int unsigned PP_NUM_STAGES = 3;
  localparam int unsigned PP_OFS_W      = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } pp_state_e;

endpackage

// File: rtl/pp_stage_slot.sv
// One delayed pipeline stage: starts at a fixed advance count, then walks the
// frame's row addresses with a ping-pong bank that flips at block ends.
module pp_stage_slot
  import pp_stage_sequencer_pkg::*;
#(
  parameter int unsigned       ADDR_W   = PP_ADDR_W,
  parameter int unsigned       BLK_LOG2 = PP_BLK_LOG2,
  parameter int unsigned       OFS_W    = PP_OFS_W,
  parameter logic [OFS_W-1:0]  OFS      = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              adv,
  input  logic              clr,
  input  logic              flush,
  input  logic [OFS_W-1:0]  tick_cnt,
  input  logic [ADDR_W:0]   total_rows,
  output logic              valid,
  output logic              bank,
  output logic [ADDR_W-1:0] addr,
  output logic              done_c
);

  logic              started_q;
  logic              fin_q;
  logic [ADDR_W:0]   last_c;
  logic [ADDR_W:0]   addr_ext_c;
  logic              start_now_c;
  logic              at_last_c;
  logic              hit_c;

  assign last_c      = total_rows - (ADDR_W+1)'(1);
  assign addr_ext_c  = {1'b0, addr};
  assign start_now_c = !started_q && (tick_cnt == OFS);
  assign at_last_c   = flush && valid && (addr_ext_c == last_c);

  // hit_c: this advance makes the stage reach its final row
  assign hit_c  = start_now_c ? (last_c == '0)
                              : (valid && ((addr_ext_c + (ADDR_W+1)'(1)) == last_c));
  assign done_c = fin_q | at_last_c | (flush & hit_c);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      started_q <= 1'b0;
      fin_q     <= 1'b0;
      valid     <= 1'b0;
      bank      <= 1'b1;
      addr      <= '0;
    end else if (clr) begin
      started_q <= 1'b0;
      fin_q     <= 1'b0;
      valid     <= 1'b0;
      bank      <= 1'b1;
      addr      <= '0;
    end else if (adv) begin
      if (start_now_c) begin
        started_q <= 1'b1;
        valid     <= 1'b1;
        addr      <= '0;
      end else if (valid) begin
        if (&addr[BLK_LOG2-1:0]) bank <= ~bank;
        if (at_last_c) begin
          valid <= 1'b0;
          fin_q <= 1'b1;
        end else begin
          addr <= addr + ADDR_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/pp_stage_sequencer.sv
// Row-per-cycle 8x8 block sequencer: input handshake, frame FSM with flush,
// and NUM_STAGES delayed stage slots that share one advance strobe.
module pp_stage_sequencer
  import pp_stage_sequencer_pkg::*;
#(
  parameter int unsigned                   ADDR_W     = PP_ADDR_W,
  parameter int unsigned                   BLK_LOG2   = PP_BLK_LOG2,
  parameter int unsigned                   NUM_STAGES = PP_NUM_STAGES,
  parameter int unsigned                   OFS_W      = PP_OFS_W,
  parameter logic [NUM_STAGES*OFS_W-1:0]   STAGE_OFS  = {8'd27, 8'd18, 8'd9}
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         in_valid,
  input  logic                         in_last,
  output logic                         in_ready,
  input  logic                         out_ready,
  output logic                         adv,
  output logic [ADDR_W-1:0]            rd_addr,
  output logic [BLK_LOG2-1:0]          row_idx,
  output logic [NUM_STAGES-1:0]        stage_valid,
  output logic [NUM_STAGES-1:0]        stage_bank,
  output logic [NUM_STAGES*ADDR_W-1:0] stage_addr,
  output logic                         busy,
  output logic                         frame_done
);

  function automatic logic [OFS_W-1:0] max_ofs();
    logic [OFS_W-1:0] m;
    m = '0;
    for (int unsigned s = 0; s < NUM_STAGES; s++) begin
      if (STAGE_OFS[s*OFS_W +: OFS_W] > m) m = STAGE_OFS[s*OFS_W +: OFS_W];
    end
    return m;
  endfunction

  localparam logic [OFS_W-1:0] MAX_OFS = max_ofs();

  pp_state_e             state_q;
  pp_state_e             state_d;
  logic [ADDR_W-1:0]     rd_addr_q;
  logic [OFS_W-1:0]      tick_q;
  logic [ADDR_W:0]       total_rows_q;
  logic                  run_c;
  logic                  flush_c;
  logic                  accept_c;
  logic                  last_acc_c;
  logic                  all_done_c;
  logic                  slot_clr_c;
  logic [NUM_STAGES-1:0] slot_done_c;

  assign run_c      = (state_q == ST_RUN);
  assign flush_c    = (state_q == ST_FLUSH);
  assign slot_clr_c = (state_q == ST_DONE);
  assign in_ready   = run_c & out_ready;
  assign adv        = out_ready & ((run_c & in_valid) | flush_c);
  assign accept_c   = in_ready & in_valid;
  // The top row address is an implicit end of frame
  assign last_acc_c = accept_c & (in_last | (&rd_addr_q));
  assign all_done_c = &slot_done_c;

  assign rd_addr    = rd_addr_q;
  assign row_idx    = rd_addr_q[BLK_LOG2-1:0];
  assign busy       = (state_q != ST_IDLE);
  assign frame_done = (state_q == ST_DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = ST_RUN;
      ST_RUN:   if (last_acc_c) state_d = ST_FLUSH;
      ST_FLUSH: if (adv && all_done_c) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Frame counters: advance count, read address and latched frame length
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_addr_q    <= '0;
      tick_q       <= '0;
      total_rows_q <= '0;
    end else if ((state_q == ST_IDLE) && start) begin
      rd_addr_q    <= '0;
      tick_q       <= '0;
      total_rows_q <= '0;
    end else begin
      if (adv && (tick_q != MAX_OFS)) tick_q <= tick_q + OFS_W'(1);
      if (accept_c && !(&rd_addr_q))  rd_addr_q <= rd_addr_q + ADDR_W'(1);
      if (last_acc_c) total_rows_q <= {1'b0, rd_addr_q} + (ADDR_W+1)'(1);
    end
  end

  for (genvar s = 0; s < NUM_STAGES; s++) begin : g_slot
    pp_stage_slot #(
      .ADDR_W   (ADDR_W),
      .BLK_LOG2 (BLK_LOG2),
      .OFS_W    (OFS_W),
      .OFS      (STAGE_OFS[s*OFS_W +: OFS_W])
    ) u_slot (
      .clk        (clk),
      .reset      (reset),
      .adv        (adv),
      .clr        (slot_clr_c),
      .flush      (flush_c),
      .tick_cnt   (tick_q),
      .total_rows (total_rows_q),
      .valid      (stage_valid[s]),
      .bank       (stage_bank[s]),
      .addr       (stage_addr[s*ADDR_W +: ADDR_W]),
      .done_c     (slot_done_c[s])
    );
  end

endmodule

// File: tb/tb_pp_stage_sequencer.sv
// Scoreboard bench: the driver queues the expected post-advance state for each
// advance it issues; a monitor pops and compares on every observed advance.
module tb_pp_stage_sequencer;

  typedef struct packed {
    logic [15:0] k;
    logic [14:0] rd;
    logic [2:0]  sv;
    logic [2:0]  sb;
    logic [44:0] sa;
    logic        fd;
  } rec_t;

  logic clk = 1'b0;
  logic reset, start, in_valid, in_last, out_ready, sel;

  logic        in_ready_a, adv_a, busy_a, fd_a;
  logic [14:0] rd_a;
  logic [2:0]  row_a, sv_a, sb_a;
  logic [44:0] sa_a;
  logic        in_ready_w, adv_w, busy_w, fd_w;
  logic [4:0]  rd_w;
  logic [2:0]  row_w, sv_w, sb_w;
  logic [14:0] sa_w;

  logic        m_adv, m_in_ready, m_busy, m_fd;
  logic [14:0] m_rd;
  logic [2:0]  m_sv, m_sb;
  logic [44:0] m_sa;

  rec_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  pp_stage_sequencer dut (
    .clk(clk), .reset(reset), .start(start & ~sel), .in_valid(in_valid & ~sel),
    .in_last(in_last), .in_ready(in_ready_a), .out_ready(out_ready), .adv(adv_a),
    .rd_addr(rd_a), .row_idx(row_a), .stage_valid(sv_a), .stage_bank(sb_a),
    .stage_addr(sa_a), .busy(busy_a), .frame_done(fd_a)
  );

  pp_stage_sequencer #(.ADDR_W(5)) dut_w (
    .clk(clk), .reset(reset), .start(start & sel), .in_valid(in_valid & sel),
    .in_last(in_last), .in_ready(in_ready_w), .out_ready(out_ready), .adv(adv_w),
    .rd_addr(rd_w), .row_idx(row_w), .stage_valid(sv_w), .stage_bank(sb_w),
    .stage_addr(sa_w), .busy(busy_w), .frame_done(fd_w)
  );

  always_comb begin
    if (sel) begin
      m_adv = adv_w; m_in_ready = in_ready_w; m_busy = busy_w; m_fd = fd_w;
      m_rd  = 15'(rd_w); m_sv = sv_w; m_sb = sb_w;
      m_sa  = {10'd0, sa_w[14:10], 10'd0, sa_w[9:5], 10'd0, sa_w[4:0]};
    end else begin
      m_adv = adv_a; m_in_ready = in_ready_a; m_busy = busy_a; m_fd = fd_a;
      m_rd  = rd_a; m_sv = sv_a; m_sb = sb_a; m_sa = sa_a;
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  function automatic bit bank_of(input int a);
    return ((a / 8) % 2) == 0;
  endfunction

  // Expected outputs right after advance number k of an n-row frame
  function automatic rec_t expect_rec(input int k, input int n, input int cap);
    rec_t r;
    int   ofs[3];
    int   a;
    bit   v, b;
    ofs  = '{9, 18, 27};
    r    = '0;
    r.k  = 16'(k);
    r.rd = 15'((k < n) ? k : ((n == cap) ? cap - 1 : n));
    for (int s = 0; s < 3; s++) begin
      if (k <= ofs[s]) begin
        a = 0; v = 1'b0; b = 1'b1;
      end else if (k <= ofs[s] + n) begin
        a = k - ofs[s] - 1; v = 1'b1; b = bank_of(a);
      end else begin
        a = n - 1; v = 1'b0; b = bank_of(n - 1) ^ (((n - 1) % 8) == 7);
      end
      r.sv[s] = v;
      r.sb[s] = b;
      r.sa[s*15 +: 15] = 15'(a);
    end
    r.fd = (k == 27 + n);
    return r;
  endfunction

  // Monitor: an advance seen mid-cycle is checked just after the following edge
  always begin : monitor
    logic a;
    rec_t e;
    @(negedge clk);
    a = m_adv;
    @(posedge clk);
    #1;
    if (a) begin
      if (exp_q.size() == 0) begin
        check("unexpected_adv", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("rd_addr@adv%0d", e.k), 64'(m_rd), 64'(e.rd));
        check($sformatf("stage_valid@adv%0d", e.k), 64'(m_sv), 64'(e.sv));
        check($sformatf("stage_bank@adv%0d", e.k), 64'(m_sb), 64'(e.sb));
        check($sformatf("stage_addr@adv%0d", e.k), 64'(m_sa), 64'(e.sa));
        check($sformatf("frame_done@adv%0d", e.k), 64'(m_fd), 64'(e.fd));
      end
    end
  end

  task automatic check_reset_state(input string tag);
    check({tag, "_rd_addr"}, 64'(m_rd), 64'd0);
    check({tag, "_stage_valid"}, 64'(m_sv), 64'd0);
    check({tag, "_stage_bank"}, 64'(m_sb), 64'h7);
    check({tag, "_stage_addr"}, 64'(m_sa), 64'd0);
    check({tag, "_busy"}, 64'(m_busy), 64'd0);
    check({tag, "_frame_done"}, 64'(m_fd), 64'd0);
    check({tag, "_in_ready"}, 64'(m_in_ready), 64'd0);
  endtask

  task automatic run_frame(input int n, input int cap, input bit implicit_last,
                           input bit bubbles, input int stall_at, input int abort_at);
    int k, rows, c;
    rec_t e;
    @(posedge clk); #2;
    start = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    k = 0; rows = 0; c = 0;
    while (rows < n && !(abort_at > 0 && rows == abort_at)) begin
      @(posedge clk); #2;
      start     = (c == 3);
      in_valid  = bubbles ? ((c % 2) == 0) : 1'b1;
      out_ready = !(stall_at >= 0 && c >= stall_at && c < stall_at + 5);
      in_last   = (rows == n - 1) && !implicit_last;
      if (in_valid && out_ready) begin
        rows++; k++;
        exp_q.push_back(expect_rec(k, n, cap));
      end else if (!out_ready) begin
        e = expect_rec(k, n, cap);
        @(negedge clk);
        check("stall_adv", 64'(m_adv), 64'd0);
        check("stall_in_ready", 64'(m_in_ready), 64'd0);
        check("stall_rd_addr", 64'(m_rd), 64'(e.rd));
        check("stall_stage_addr", 64'(m_sa), 64'(e.sa));
      end
      c++;
    end
    if (abort_at > 0) return;
    // Flush: upstream keeps offering rows that must not be taken
    while (k < 27 + n) begin
      @(posedge clk); #2;
      start = 1'b0; in_last = 1'b0; out_ready = 1'b1;
      in_valid = ((k % 3) == 0);
      k++;
      exp_q.push_back(expect_rec(k, n, cap));
    end
    @(posedge clk); #2;
    in_valid = 1'b0;
    for (int i = 0; i < 4 && m_busy; i++) begin
      @(posedge clk); #1;
    end
    check("idle_after_frame", 64'(m_busy), 64'd0);
    check("done_is_pulse", 64'(m_fd), 64'd0);
    check("idle_stage_valid", 64'(m_sv), 64'd0);
    check("idle_stage_bank", 64'(m_sb), 64'h7);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sel = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    reset = 1'b0;
    #12;
    check_reset_state("por");
    @(negedge clk); reset = 1'b1;

    run_frame(16, 32768, 1'b0, 1'b0, -1, 0);   // continuous
    run_frame(16, 32768, 1'b0, 1'b0, 6, 0);    // 5-cycle stall
    run_frame(16, 32768, 1'b0, 1'b1, -1, 0);   // upstream bubbles
    run_frame(4, 32768, 1'b0, 1'b0, -1, 0);    // short frame

    // Reset in the middle of a frame after 12 rows
    run_frame(16, 32768, 1'b0, 1'b0, -1, 12);
    @(posedge clk); #2;
    in_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check_reset_state("midreset");
    check("midreset_pending", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    @(negedge clk); reset = 1'b1;
    run_frame(16, 32768, 1'b0, 1'b0, -1, 0);

    // Narrow instance: full address space without in_last
    sel = 1'b1;
    run_frame(32, 32, 1'b1, 1'b0, -1, 0);

    @(posedge clk); #2;
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
